// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage load/store request into a word-wide
// request/acknowledge memory access and returns a single-cycle response.
module load_store_unit #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_load_type,
   input  logic [1:0]        req_store_type,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   // Last counter value before expiry; unused when TIMEOUT_CYCLES is 0.
   localparam logic [CNT_W-1:0] TO_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   function automatic logic [3:0] store_strb(input logic [1:0] st, input logic [1:0] lane);
      logic [3:0] s;
      case (st)
         2'b00:   s = 4'b0001 << lane;
         2'b01:   s = lane[1] ? 4'b1100 : 4'b0011;
         2'b10:   s = 4'b1111;
         default: s = 4'b0000;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] st, input logic [31:0] wd);
      logic [31:0] d;
      case (st)
         2'b00:   d = {4{wd[7:0]}};
         2'b01:   d = {2{wd[15:0]}};
         2'b10:   d = wd;
         default: d = 32'h0000_0000;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] lt, input logic [1:0] lane,
                                                input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'b00:   b = w[7:0];
         2'b01:   b = w[15:8];
         2'b10:   b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lane[1] ? w[31:16] : w[15:0];
      case (lt)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'h00_0000, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'h0000, h};
         3'b010:  r = w;
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   state_t            state_q;
   logic              req_ready_q, rsp_valid_q, rsp_err_q;
   logic [31:0]       rsp_rdata_q;
   logic              mem_req_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [3:0]        mem_wstrb_q;
   logic [31:0]       mem_wdata_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        ltype_q;
   logic [1:0]        lane_q;
   logic              legal_d, aligned_d;

   // Request decode: type legality and natural alignment.
   always_comb begin
      legal_d   = 1'b0;
      aligned_d = 1'b0;
      if (req_we) begin
         case (req_store_type)
            2'b00:   begin legal_d = 1'b1; aligned_d = 1'b1;                     end
            2'b01:   begin legal_d = 1'b1; aligned_d = ~req_addr[0];             end
            2'b10:   begin legal_d = 1'b1; aligned_d = (req_addr[1:0] == 2'b00); end
            default: begin legal_d = 1'b0; aligned_d = 1'b0;                     end
         endcase
      end else begin
         case (req_load_type)
            3'b000, 3'b100: begin legal_d = 1'b1; aligned_d = 1'b1;                     end
            3'b001, 3'b101: begin legal_d = 1'b1; aligned_d = ~req_addr[0];             end
            3'b010:         begin legal_d = 1'b1; aligned_d = (req_addr[1:0] == 2'b00); end
            default:        begin legal_d = 1'b0; aligned_d = 1'b0;                     end
         endcase
      end
   end

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wstrb_q <= 4'b0000;
         mem_wdata_q <= 32'h0000_0000;
         cnt_q       <= '0;
         ltype_q     <= 3'b000;
         lane_q      <= 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_ready_q <= 1'b0;
                  ltype_q     <= req_load_type;
                  lane_q      <= req_addr[1:0];
                  if (legal_d && aligned_d) begin
                     state_q     <= ACCESS;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= req_we;
                     mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_wstrb_q <= req_we ? store_strb(req_store_type, req_addr[1:0]) : 4'b0000;
                     mem_wdata_q <= req_we ? store_data(req_store_type, req_wdata) : 32'h0000_0000;
                     cnt_q       <= '0;
                  end else begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= 32'h0000_0000;
                  end
               end
            end
            ACCESS: begin
               // An ack in the expiring cycle completes the access normally.
               if (mem_ack) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= mem_we_q ? 32'h0000_0000 : load_extract(ltype_q, lane_q, mem_rdata);
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_wstrb_q <= 4'b0000;
                  mem_wdata_q <= 32'h0000_0000;
               end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 32'h0000_0000;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_wstrb_q <= 4'b0000;
                  mem_wdata_q <= 32'h0000_0000;
                  cnt_q       <= cnt_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= 32'h0000_0000;
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               mem_req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wstrb = mem_wstrb_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit, built with a 4-cycle timeout.
module tb_load_store_unit;

   logic        clk, rst_n, req_valid, req_we, mem_ack;
   logic [2:0]  req_load_type;
   logic [1:0]  req_store_type;
   logic [31:0] req_addr, req_wdata, mem_rdata;
   logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   int          checks = 0;
   int          errors = 0;

   load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_load_type(req_load_type), .req_store_type(req_store_type),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for exactly one edge (the accept edge).
   task automatic send(input logic we, input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] wd);
      req_valid = 1'b1; req_we = we; req_load_type = lt; req_store_type = st;
      req_addr = addr; req_wdata = wd;
      tick();
      req_valid = 1'b0;
   endtask

   // Let n ACCESS edges pass without ack, then ack on the next edge.
   task automatic ack_after(input int n, input logic [31:0] rd);
      repeat (n) tick();
      mem_ack = 1'b1; mem_rdata = rd;
      tick();
      mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_load_type = 3'b000;
      req_store_type = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (2) tick();
      checks++;
      if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we} !== 5'b10000) begin
         errors++; $display("FAIL reset_flags got %b want 10000", {req_ready, rsp_valid, rsp_err, mem_req, mem_we});
      end
      checks++;
      if ({rsp_rdata, mem_addr, mem_wdata, mem_wstrb} !== 100'h0) begin
         errors++; $display("FAIL reset_data got %h %h %h %h want zeros", rsp_rdata, mem_addr, mem_wdata, mem_wstrb);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_store_word();
      send(1'b1, 3'b000, 2'b10, 32'h0000_0104, 32'hDEAD_BEEF);
      checks++;
      if ({mem_req, mem_we, mem_wstrb, req_ready, rsp_valid} !== 8'b11_1111_00) begin
         errors++; $display("FAIL sw_ctrl got %b want 11111100", {mem_req, mem_we, mem_wstrb, req_ready, rsp_valid});
      end
      checks++;
      if (mem_addr !== 32'h0000_0104 || mem_wdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL sw_addr_data got %h %h want 00000104 deadbeef", mem_addr, mem_wdata);
      end
      ack_after(0, 32'h5555_5555);
      checks++;
      if ({rsp_valid, rsp_err, mem_req} !== 3'b100 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL sw_rsp got v%b e%b req%b d%h want v1 e0 req0 d0", rsp_valid, rsp_err, mem_req, rsp_rdata);
      end
      tick();
      checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         errors++; $display("FAIL sw_after got v%b rdy%b want v0 rdy1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_store_lanes();
      logic [31:0] a [4];
      logic [1:0]  st [4];
      logic [31:0] wd [4];
      logic [3:0]  es [4];
      logic [31:0] ed [4];
      a  = '{32'h203, 32'h202, 32'h200, 32'h201};
      st = '{2'b00, 2'b01, 2'b01, 2'b00};
      wd = '{32'h1234_56A5, 32'h0000_1234, 32'hABCD_5678, 32'h0000_003C};
      es = '{4'b1000, 4'b1100, 4'b0011, 4'b0010};
      ed = '{32'hA5A5_A5A5, 32'h1234_1234, 32'h5678_5678, 32'h3C3C_3C3C};
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 3'b111, st[i], a[i], wd[i]);
         checks++;
         if ({mem_req, mem_we, mem_wstrb} !== {2'b11, es[i]} || mem_addr !== 32'h200 || mem_wdata !== ed[i]) begin
            errors++; $display("FAIL store_lane%0d got req%b we%b strb%b a%h d%h want strb%b a00000200 d%h",
                               i, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, es[i], ed[i]);
         end
         ack_after(i % 2, 32'hFFFF_FFFF);
         checks++;
         if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL store_rsp%0d got v%b e%b d%h want v1 e0 d0", i, rsp_valid, rsp_err, rsp_rdata);
         end
         tick();
      end
   endtask

   task automatic test_loads();
      logic [2:0]  lt [8];
      logic [31:0] a  [8];
      logic [31:0] ex [8];
      lt = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001, 3'b100};
      a  = '{32'h302, 32'h302, 32'h302, 32'h300, 32'h300, 32'h301, 32'h300, 32'h303};
      ex = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01,
             32'h80FF_7F01, 32'h0000_007F, 32'h0000_7F01, 32'h0000_0080};
      for (int i = 0; i < 8; i++) begin
         send(1'b0, lt[i], 2'b11, a[i], 32'hFFFF_FFFF);
         checks++;
         if ({mem_req, mem_we, mem_wstrb} !== 6'b10_0000 || mem_addr !== 32'h300) begin
            errors++; $display("FAIL load_req%0d got req%b we%b strb%b a%h want req1 we0 strb0000 a00000300",
                               i, mem_req, mem_we, mem_wstrb, mem_addr);
         end
         ack_after(i % 3, 32'h80FF_7F01);
         checks++;
         if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== ex[i]) begin
            errors++; $display("FAIL load_data%0d got v%b e%b d%h want v1 e0 d%h", i, rsp_valid, rsp_err, rsp_rdata, ex[i]);
         end
         tick();
      end
   endtask

   task automatic test_errors();
      logic        we [8];
      logic [2:0]  lt [8];
      logic [1:0]  st [8];
      logic [31:0] a  [8];
      we = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      lt = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b000, 3'b000, 3'b000};
      st = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01};
      a  = '{32'h101, 32'h102, 32'h100, 32'h100, 32'h100, 32'h100, 32'h101, 32'h103};
      for (int i = 0; i < 8; i++) begin
         send(we[i], lt[i], st[i], a[i], 32'h1234_5678);
         checks++;
         if ({mem_req, rsp_valid, rsp_err, req_ready} !== 4'b0110 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL err_rsp%0d got req%b v%b e%b rdy%b d%h want req0 v1 e1 rdy0 d0",
                               i, mem_req, rsp_valid, rsp_err, req_ready, rsp_rdata);
         end
         tick();
         checks++;
         if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin
            errors++; $display("FAIL err_after%0d got req%b v%b rdy%b want req0 v0 rdy1", i, mem_req, rsp_valid, req_ready);
         end
      end
   endtask

   task automatic test_timeout();
      send(1'b0, 3'b010, 2'b00, 32'h0000_0400, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({mem_req, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL to_wait%0d got req%b v%b want req1 v0", i, mem_req, rsp_valid);
         end
         tick();
      end
      checks++;
      if ({mem_req, rsp_valid, rsp_err} !== 3'b011 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL to_expire got req%b v%b e%b d%h want req0 v1 e1 d0", mem_req, rsp_valid, rsp_err, rsp_rdata);
      end
      mem_ack = 1'b1; mem_rdata = 32'hAAAA_AAAA;
      tick();
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, rsp_valid, rsp_err, req_ready} !== 4'b0001) begin
         errors++; $display("FAIL to_late_ack got req%b v%b e%b rdy%b want 0001", mem_req, rsp_valid, rsp_err, req_ready);
      end
      send(1'b0, 3'b010, 2'b00, 32'h0000_0400, 32'h0);
      ack_after(3, 32'h1122_3344);
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h1122_3344) begin
         errors++; $display("FAIL to_ack_last got v%b e%b d%h want v1 e0 d11223344", rsp_valid, rsp_err, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int pulses;
      send(1'b0, 3'b010, 2'b00, 32'h0000_0500, 32'h0);
      tick();
      checks++;
      if (mem_req !== 1'b1) begin
         errors++; $display("FAIL rst_mid_pre got req%b want 1", mem_req);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0) begin
         errors++; $display("FAIL rst_mid_drop got req%b want 0", mem_req);
      end
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rsp_valid !== 1'b0) pulses++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (rsp_valid !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL rst_mid_idle got pulses %0d rdy%b want pulses 0 rdy1", pulses, req_ready);
      end
      send(1'b0, 3'b010, 2'b00, 32'h0000_0504, 32'h0);
      ack_after(0, 32'hCAFE_F00D);
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL rst_mid_lw got v%b e%b d%h want v1 e0 dcafef00d", rsp_valid, rsp_err, rsp_rdata);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_store_word();
      test_store_lanes();
      test_loads();
      test_errors();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory responder for the core's load/store control outputs. It accepts one load or store request per transaction, with RISC-V funct3-encoded type select, byte address and store data. It performs byte-lane alignment, write strobes and load sign/zero extension, and drives a word-wide request/acknowledge memory port. It returns a single-cycle response carrying the load data or an error flag, and sits between the execute stage and data memory.

Parameters:
ADDR_W, 32, byte-address width
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack before error; 0 = wait forever
CNT_W, 8, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit idle, accepts request
req_we  input  1  1 = store, 0 = load
req_load_type  input  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
req_store_type  input  2  funct3[1:0]: 00 SB, 01 SH, 10 SW
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, LSB-justified
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned, illegal type or timeout
mem_req  output  1  memory request, held until ack
mem_we  output  1  memory write
mem_addr  output  ADDR_W  word-aligned address, bits [1:0] = 00
mem_wstrb  output  4  byte write strobes, 0000 on reads
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory done; read data valid same cycle
mem_rdata  input  32  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_req=0; mem_we=0; mem_addr=0; mem_wstrb=0; mem_wdata=0; timeout counter 0. Reset mid-transaction aborts immediately (mem_req drops asynchronously) and no response is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid at edge T, request is captured. If legal and aligned, next state is ACCESS and mem_* are registered at T+1. Otherwise next state is RESP with rsp_err=1, and mem_req is never raised.
- Illegal types: load 011, 110, 111; store 11.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
- ACCESS: req_ready=0. mem_req=1, and mem_addr/mem_we/mem_wstrb/mem_wdata are held stable until mem_ack. When mem_ack=1 at an edge, the unit captures the extended load data, drops mem_req and goes to RESP.
  - Counter increments each ACCESS cycle without ack.
  - If TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES, the unit drops mem_req and goes to RESP with rsp_err=1 and rdata=0.
  - Ack in the same cycle the count would expire: the ack wins.
- RESP: rsp_valid=1 for exactly one cycle, with no backpressure, then IDLE. req_ready=0, so the next request is accepted no earlier than the following cycle.
- mem_ack outside ACCESS is ignored, including a late ack after timeout.
- Minimum load/store latency: accept at T, mem_req at T+1, ack at T+1, rsp_valid at T+2. Error with no memory access: rsp_valid at T+1.
- Store formatting, lane = addr[1:0]:
  - SB: wdata = {4{wdata[7:0]}}, wstrb = 0001<<lane.
  - SH: wdata = {2{wdata[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata unchanged, wstrb = 1111.
- Load extraction:
  - LB/LBU: byte mem_rdata[8*lane+7:8*lane], sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: half mem_rdata[16*addr[1]+15:16*addr[1]], sign-extended (LH) or zero-extended (LHU).
  - LW: full word.
- Stores: rsp_rdata=0, rsp_err=0 on success.
- req_load_type is ignored when req_we=1; req_store_type is ignored when req_we=0.

Test Plan:
- SW addr 0x104, wdata 0xDEADBEEF, ack at 1st ACCESS cycle -> mem_addr 0x104, wstrb 1111, wdata 0xDEADBEEF, rsp_valid 2 cycles after accept, rsp_err 0.
- SB addr 0x203, wdata 0x000000A5 -> mem_addr 0x200, wstrb 1000, wdata 0xA5A5A5A5; SH addr 0x202, wdata 0x1234 -> wstrb 1100, wdata 0x12341234.
- mem_rdata 0x80FF7F01: LB addr 0x x2 -> 0xFFFFFFFF; LBU same -> 0x000000FF; LH addr x2 -> 0xFFFF80FF; LHU addr x0 -> 0x00007F01; LW -> 0x80FF7F01.
- LH addr 0x101; LW addr 0x102; load type 011 -> mem_req never asserted, rsp_valid next cycle with rsp_err 1, rsp_rdata 0.
- TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles then low, rsp_err 1; late ack ignored; ack on 4th cycle -> success.
- rst_n low during ACCESS -> mem_req 0 immediately, no rsp_valid; after release req_ready=1 and a new LW completes normally.
